// File: rtl/pipeline_step_ctrl.sv
// Clock-enable sequencer for the lab pipeline CPU.
// Turns the bouncy step button into single-cycle pipe_en pulses, free-runs the
// pipeline at a divided rate in run mode, and halts when the IF-stage PC hits
// an enabled breakpoint at a run-mode pulse slot.
module pipeline_step_ctrl #(
  parameter int DB_CNT  = 3,
  parameter int RUN_DIV = 4,
  parameter int PC_W    = 32
) (
  input  logic            i_cclk,
  input  logic            i_rst_n,
  input  logic            i_btn_step,
  input  logic            i_mode_run,
  input  logic            i_bp_en,
  input  logic [PC_W-1:0] i_bp_addr,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_pipe_en,
  output logic            o_halted,
  output logic [1:0]      o_state,
  output logic [15:0]     o_step_cnt
);

  localparam int DB_W  = (DB_CNT  > 1) ? $clog2(DB_CNT)  : 1;
  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CNT - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    ST_STEP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  logic             r_s1;
  logic             r_s2;
  logic             r_btn_db;
  logic             r_btn_db_q;
  logic [DB_W-1:0]  r_db_cnt;
  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pipe_en;
  logic             r_halted;
  logic [15:0]      r_step_cnt;

  state_t           w_next_state;
  logic             w_pulse;
  logic             w_div_clr;
  logic             w_press;
  logic             w_slot;
  logic             w_bp_hit;

  assign w_press  = r_btn_db & ~r_btn_db_q;
  assign w_slot   = (r_div_cnt == DIV_LAST);
  assign w_bp_hit = i_bp_en && (i_pc == i_bp_addr);

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge i_cclk) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn_step;
      r_s2 <= r_s1;
    end
  end

  // Debounce: accept a new level only after it has persisted DB_CNT cycles.
  always_ff @(posedge i_cclk) begin
    if (!i_rst_n) begin
      r_btn_db   <= 1'b0;
      r_btn_db_q <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_btn_db_q <= r_btn_db;
      if (r_s2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_btn_db <= r_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // State register plus the registered pulse, halt flag, divider and counter.
  always_ff @(posedge i_cclk) begin
    if (!i_rst_n) begin
      r_state    <= ST_STEP;
      r_halted   <= 1'b0;
      r_pipe_en  <= 1'b0;
      r_div_cnt  <= '0;
      r_step_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_halted   <= (w_next_state == ST_HALT);
      r_pipe_en  <= w_pulse;
      r_step_cnt <= r_step_cnt + {15'd0, w_pulse};
      if (w_div_clr) begin
        r_div_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_div_cnt <= w_slot ? '0 : r_div_cnt + DIV_W'(1);
      end
    end
  end

  // Next-state and pulse decision; mode switch wins over slot and breakpoint.
  always_comb begin
    w_next_state = r_state;
    w_pulse      = 1'b0;
    w_div_clr    = 1'b0;
    unique case (r_state)
      ST_STEP: begin
        if (i_mode_run) begin
          w_next_state = ST_RUN;
          w_div_clr    = 1'b1;
        end else if (w_press) begin
          w_pulse = 1'b1;
        end
      end
      ST_RUN: begin
        if (!i_mode_run) begin
          w_next_state = ST_STEP;
        end else if (w_slot) begin
          if (w_bp_hit) begin
            w_next_state = ST_HALT;
          end else begin
            w_pulse = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (w_press) begin
          w_pulse = 1'b1;
          if (i_mode_run) begin
            w_next_state = ST_RUN;
            w_div_clr    = 1'b1;
          end else begin
            w_next_state = ST_STEP;
          end
        end else if (!i_mode_run) begin
          w_next_state = ST_STEP;
        end
      end
      default: w_next_state = ST_STEP;
    endcase
  end

  // Outputs come straight from registers so pipe_en is glitch-free.
  always_comb begin
    o_pipe_en  = r_pipe_en;
    o_halted   = r_halted;
    o_state    = r_state;
    o_step_cnt = r_step_cnt;
  end

endmodule
